regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
Scoreboard and stall controller for the 32x32 two-read/one-write register file in the stalling pipeline.
- Tracks in-flight writes per architectural register.
- Blocks decode-stage issue while a source (RAW) or destination (WAW saturation) register has pending writes.
- Retires pending writes on writeback.
- Sits between decode and the register file read ports; drives the pipeline stall signal.

Parameters:
NUM_REGS, 32, number of architectural registers (register 0 hardwired zero, never tracked)
ADDR_W, 5, register address width
CNT_W, 2, width of per-register pending-write counter (max pending = 2^CNT_W - 1 = 3)
STALL_CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
flush  input  1  pipeline flush; clears all pending counters at next edge
issue_valid  input  1  decode stage presents an instruction
issue_rs  input  ADDR_W  first source register address
issue_rt  input  ADDR_W  second source register address
issue_uses_rs  input  1  instruction reads rs
issue_uses_rt  input  1  instruction reads rt
issue_writes  input  1  instruction will write a register
issue_dest  input  ADDR_W  destination register address
issue_ready  output  1  no hazard; instruction may advance this cycle (combinational)
stall  output  1  issue_valid & ~issue_ready (combinational)
wb_valid  input  1  writeback stage commits a register write this cycle
wb_dest  input  ADDR_W  register written by writeback
busy_vec  output  NUM_REGS  bit r = 1 when cnt[r] != 0; bit 0 always 0
wb_underflow  output  1  sticky error: writeback to register with cnt = 0
stall_cycles  output  STALL_CNT_W  saturating count of stalled cycles

Behaviour:
- State: cnt[1..NUM_REGS-1], each CNT_W bits; wb_underflow; stall_cycles. No counter for register 0.
- Reset (rst = 1 at edge):
  - all cnt = 0, wb_underflow = 0, stall_cycles = 0.
  - Outputs after reset: busy_vec = 0, issue_ready = 1, stall = 0.
  - rst overrides flush, issue and wb in the same cycle.
- Hazard (combinational, current-cycle cnt values only):
  - raw_rs = issue_uses_rs & (issue_rs != 0) & (cnt[issue_rs] != 0)
  - raw_rt = issue_uses_rt & (issue_rt != 0) & (cnt[issue_rt] != 0)
  - waw_full = issue_writes & (issue_dest != 0) & (cnt[issue_dest] == max)
  - issue_ready = ~(raw_rs | raw_rt | waw_full)
  - issue_ready does not depend on issue_valid.
- No same-cycle bypass:
  - A wb_valid retiring the last pending write of a source register in cycle N does not clear the hazard in cycle N.
  - Issue proceeds in cycle N+1.
  - The register file write lands at the same edge the counter decrements.
- Fire: fire = issue_valid & issue_ready & issue_writes & (issue_dest != 0).
- Counter update per register r (r != 0), at each edge when rst = 0, flush = 0:
  - inc = fire & (issue_dest == r)
  - dec = wb_valid & (wb_dest == r) & (cnt[r] != 0)
  - inc & ~dec -> cnt+1; dec & ~inc -> cnt-1; both or neither -> unchanged.
- Writeback boundary cases:
  - wb_valid with wb_dest = 0: ignored, no error.
  - wb_valid with wb_dest != 0 and cnt = 0: counter stays 0, wb_underflow set to 1 at that edge, stays 1 until rst.
  - A same-cycle inc to that register does not mask the underflow: cnt becomes 1, underflow still flagged.
- Flush (flush = 1, rst = 0):
  - all cnt = 0 at next edge; issue and wb in that cycle are discarded for counter purposes.
  - stall_cycles still counts the cycle if stall = 1.
  - wb_underflow unchanged.
- stall_cycles: increments at each edge where stall = 1 and rst = 0; saturates at all-ones, never wraps.
- Latency: busy_vec and hazard reflect a fired issue one cycle after the fire edge.
- RTL must be fully synchronous. No latches; no combinational write paths into the counter state.

Test Plan:
- Reset:
  - Assert rst 2 cycles with issue_valid = 1, wb_valid = 1 -> busy_vec = 0, stall_cycles = 0, wb_underflow = 0, issue_ready = 1.
- RAW stall and release:
  - Fire dest = 8.
  - Next cycle, issue rs = 8 uses_rs -> stall = 1.
  - wb_dest = 8 in cycle N -> stall still 1 in N, 0 in N+1.
  - stall_cycles equals the number of stalled cycles.
- Register 0 and unused sources:
  - Fire dest = 0 -> busy_vec stays 0.
  - Issue rs = 0 with cnt irrelevant -> no stall.
  - rt = 5 pending with uses_rt = 0 -> no stall.
- WAW saturation:
  - Fire dest = 3 three times -> cnt[3] = 3, fourth issue with dest = 3 stalls.
  - One wb_dest = 3 -> next cycle ready.
  - Simultaneous fire dest = 3 and wb_dest = 3 -> cnt unchanged.
- Underflow and flush:
  - wb_dest = 12 with cnt = 0 -> wb_underflow = 1 and stays 1.
  - With regs 2 and 7 pending, assert flush alongside fire dest = 9 -> next cycle busy_vec = 0, wb_underflow still 1.
- Counter saturation:
  - Force stall continuously for 65540 cycles -> stall_cycles = 16'hFFFF, holds.

Source files
------------

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback <-> scoreboard bundle.
//   master : decode + writeback side (drives flush, issue_*, wb_*)
//   slave  : scoreboard (drives issue_ready, stall, busy_vec, wb_underflow,
//            stall_cycles)
interface regfile_scoreboard_if #(
   parameter int NUM_REGS    = 32,
   parameter int ADDR_W      = 5,
   parameter int STALL_CNT_W = 16
);
   logic                   flush;
   logic                   issue_valid;
   logic [ADDR_W-1:0]      issue_rs;
   logic [ADDR_W-1:0]      issue_rt;
   logic                   issue_uses_rs;
   logic                   issue_uses_rt;
   logic                   issue_writes;
   logic [ADDR_W-1:0]      issue_dest;
   logic                   issue_ready;
   logic                   stall;
   logic                   wb_valid;
   logic [ADDR_W-1:0]      wb_dest;
   logic [NUM_REGS-1:0]    busy_vec;
   logic                   wb_underflow;
   logic [STALL_CNT_W-1:0] stall_cycles;

   modport master (
      output flush, issue_valid, issue_rs, issue_rt, issue_uses_rs,
             issue_uses_rt, issue_writes, issue_dest, wb_valid, wb_dest,
      input  issue_ready, stall, busy_vec, wb_underflow, stall_cycles
   );

   modport slave (
      input  flush, issue_valid, issue_rs, issue_rt, issue_uses_rs,
             issue_uses_rt, issue_writes, issue_dest, wb_valid, wb_dest,
      output issue_ready, stall, busy_vec, wb_underflow, stall_cycles
   );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register-file scoreboard and stall controller.
// Tracks pending writes per architectural register (r0 never tracked),
// blocks issue on RAW hazards and on WAW counter saturation, retires
// pending writes on writeback.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   sb       : regfile_scoreboard_if.slave (issue, writeback, status)

// One pending-write counter. uflow_o flags a writeback that found the
// counter already at zero (combinational; the sticky flag lives in the top).
module regfile_scoreboard_cnt #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             inc_i,
   input  logic             wb_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             uflow_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dec;

   assign dec     = wb_i & (cnt_q != '0);
   assign uflow_o = wb_i & (cnt_q == '0);
   assign cnt_o   = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (flush_i)          cnt_d = '0;
      else if (inc_i & ~dec) cnt_d = cnt_q + CNT_W'(1);
      else if (dec & ~inc_i) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

module regfile_scoreboard #(
   parameter int NUM_REGS    = 32,
   parameter int ADDR_W      = 5,
   parameter int CNT_W       = 2,
   parameter int STALL_CNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   regfile_scoreboard_if.slave sb
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Entry 0 is a constant zero so r0 lookups never report a hazard.
   logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
   logic [NUM_REGS-1:1]            inc, wb_hit, uflow;

   logic                   raw_rs, raw_rt, waw_full, ready, fire;
   logic                   uflow_q, uflow_d;
   logic [STALL_CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   assign cnt[0] = '0;

   // Hazards look only at the registered counts: a writeback retiring the
   // last pending write does not release a waiting reader in the same cycle.
   always_comb begin
      raw_rs   = sb.issue_uses_rs & (sb.issue_rs != '0) & (cnt[sb.issue_rs] != '0);
      raw_rt   = sb.issue_uses_rt & (sb.issue_rt != '0) & (cnt[sb.issue_rt] != '0);
      waw_full = sb.issue_writes & (sb.issue_dest != '0) & (cnt[sb.issue_dest] == CNT_MAX);
      ready    = ~(raw_rs | raw_rt | waw_full);
      fire     = sb.issue_valid & ready & sb.issue_writes & (sb.issue_dest != '0);
   end

   for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
      assign inc[r]    = fire & (sb.issue_dest == ADDR_W'(r));
      assign wb_hit[r] = sb.wb_valid & (sb.wb_dest == ADDR_W'(r));

      regfile_scoreboard_cnt #(.CNT_W(CNT_W)) u_cnt (
         .clk     (clk),
         .rst     (rst),
         .flush_i (sb.flush),
         .inc_i   (inc[r]),
         .wb_i    (wb_hit[r]),
         .cnt_o   (cnt[r]),
         .uflow_o (uflow[r])
      );
   end

   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) sb.busy_vec[r] = (cnt[r] != '0);
   end

   assign sb.issue_ready  = ready;
   assign sb.stall        = sb.issue_valid & ~ready;
   assign sb.wb_underflow = uflow_q;
   assign sb.stall_cycles = stall_cycles_q;

   // Underflow is sticky; writebacks are discarded during a flush, so they
   // cannot raise it then.
   always_comb begin
      uflow_d        = uflow_q | (~sb.flush & (|uflow));
      stall_cycles_d = stall_cycles_q;
      if (sb.stall && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + STALL_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         uflow_q        <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         uflow_q        <= uflow_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end
endmodule
